// File: rtl/bmp_header_parser.sv
// Byte-serial BMP header reader: fetches the 54-byte file/info header from image memory,
// validates it and publishes the image geometry used by the downstream crop datapath.
module bmp_header_parser #(
    parameter int unsigned        ADDR_W    = 16,
    parameter logic [ADDR_W-1:0]  BASE_ADDR = '0,
    parameter int unsigned        REQ_BPP   = 24
) (
    input  logic              CLOCK_50,
    input  logic              rst_n,
    input  logic              start,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [7:0]        rd_data,
    output logic              busy,
    output logic              done,
    output logic [2:0]        err_code,
    output logic [15:0]       img_width,
    output logic [15:0]       img_height,
    output logic              top_down,
    output logic [31:0]       pix_offset,
    output logic [17:0]       row_stride,
    output logic [31:0]       pix_bytes
);

    typedef enum logic [1:0] {IDLE, READ, DRAIN, CALC} state_t;

    state_t      state;
    logic [5:0]  rd_cnt;
    logic        vld_p0;
    logic [5:0]  idx_p0;
    logic [7:0]  hdr [0:53];

    logic [31:0]        bf_off;
    logic [31:0]        bi_width;
    logic signed [31:0] bi_height;
    logic [15:0]        bi_bpp;
    logic [31:0]        bi_comp;
    logic [15:0]        height_mag;
    logic [17:0]        stride_calc;

    function automatic logic [15:0] abs_trunc(input logic signed [31:0] v);
        logic [15:0] lo;
        lo = v[15:0];
        return v[31] ? (16'd0 - lo) : lo;
    endfunction

    function automatic logic [17:0] calc_stride(input logic [15:0] w);
        return (18'(w) * 18'd3 + 18'd3) & ~18'd3;
    endfunction

    // Only the low 32 bits of the 18x16 product are kept, so a 32-bit multiply suffices.
    function automatic logic [31:0] calc_pix(input logic [17:0] s, input logic [15:0] h);
        return 32'(s) * 32'(h);
    endfunction

    function automatic logic [2:0] check_hdr(input logic [7:0] sig0, input logic [7:0] sig1,
                                             input logic [15:0] bpp, input logic [31:0] comp,
                                             input logic [31:0] w, input logic signed [31:0] h,
                                             input logic [31:0] off);
        if (sig0 != 8'h42 || sig1 != 8'h4D)          return 3'd1;
        if (bpp != 16'(REQ_BPP))                     return 3'd2;
        if (comp != 32'd0)                           return 3'd3;
        if (w == 32'd0 || w[31:16] != 16'd0 || h == 32'sd0) return 3'd4;
        if (off < 32'd54)                            return 3'd5;
        return 3'd0;
    endfunction

    assign bf_off      = {hdr[13], hdr[12], hdr[11], hdr[10]};
    assign bi_width    = {hdr[21], hdr[20], hdr[19], hdr[18]};
    assign bi_height   = {hdr[25], hdr[24], hdr[23], hdr[22]};
    assign bi_bpp      = {hdr[29], hdr[28]};
    assign bi_comp     = {hdr[33], hdr[32], hdr[31], hdr[30]};
    assign height_mag  = abs_trunc(bi_height);
    assign stride_calc = calc_stride(bi_width[15:0]);

    // Stage p0 -> capture: memory answers one cycle after the strobe.
    always_ff @(posedge CLOCK_50) begin
        if (vld_p0) begin
            hdr[idx_p0] <= rd_data;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            rd_en      <= 1'b0;
            rd_addr    <= BASE_ADDR;
            rd_cnt     <= 6'd0;
            vld_p0     <= 1'b0;
            idx_p0     <= 6'd0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err_code   <= 3'd0;
            img_width  <= 16'd0;
            img_height <= 16'd0;
            top_down   <= 1'b0;
            pix_offset <= 32'd0;
            row_stride <= 18'd0;
            pix_bytes  <= 32'd0;
        end else begin
            vld_p0 <= rd_en;
            idx_p0 <= rd_cnt;
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= READ;
                        busy    <= 1'b1;
                        rd_en   <= 1'b1;
                        rd_addr <= BASE_ADDR;
                        rd_cnt  <= 6'd0;
                    end
                end
                READ: begin
                    if (rd_cnt == 6'd53) begin
                        rd_en <= 1'b0;
                        state <= DRAIN;
                    end else begin
                        rd_cnt  <= rd_cnt + 6'd1;
                        rd_addr <= rd_addr + ADDR_W'(1);
                    end
                end
                DRAIN: state <= CALC;
                CALC: begin
                    // CALC spans the result cycle and the done cycle, so a start
                    // coinciding with done is still seen outside IDLE.
                    if (!done) begin
                        done       <= 1'b1;
                        busy       <= 1'b0;
                        err_code   <= check_hdr(hdr[0], hdr[1], bi_bpp, bi_comp,
                                                bi_width, bi_height, bf_off);
                        img_width  <= bi_width[15:0];
                        img_height <= height_mag;
                        top_down   <= bi_height[31];
                        pix_offset <= bf_off;
                        row_stride <= stride_calc;
                        pix_bytes  <= calc_pix(stride_calc, height_mag);
                    end else begin
                        done  <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bmp_header_parser.sv
// Self-checking bench for bmp_header_parser: directed vector table, reset/start corner
// sequences and randomized headers checked against an arithmetic reference model.
module tb_bmp_header_parser;

    logic        CLOCK_50 = 1'b0;
    logic        rst_n;
    logic        start;
    logic        rd_en;
    logic [15:0] rd_addr;
    logic [7:0]  rd_data = 8'd0;
    logic        busy, done, top_down;
    logic [2:0]  err_code;
    logic [15:0] img_width, img_height;
    logic [31:0] pix_offset, pix_bytes;
    logic [17:0] row_stride;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    logic [7:0]  mem [0:63];
    logic [15:0] addr_q [$];

    typedef struct {
        logic [7:0]  s0, s1;
        logic [31:0] off, w, h;
        logic [15:0] bpp;
        logic [31:0] comp;
        logic [2:0]  e_err;
        logic [15:0] e_w, e_h;
        logic        e_td;
        logic [31:0] e_off;
        logic [17:0] e_stride;
        logic [31:0] e_pix;
    } vec_t;

    vec_t tbl [9];

    bmp_header_parser dut (
        .CLOCK_50  (CLOCK_50),
        .rst_n     (rst_n),
        .start     (start),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .busy      (busy),
        .done      (done),
        .err_code  (err_code),
        .img_width (img_width),
        .img_height(img_height),
        .top_down  (top_down),
        .pix_offset(pix_offset),
        .row_stride(row_stride),
        .pix_bytes (pix_bytes)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // Synchronous-read image memory with an address log.
    always @(posedge CLOCK_50) begin
        if (rd_en) begin
            rd_data <= mem[rd_addr[5:0]];
            addr_q.push_back(rd_addr);
        end
        if (done === 1'b1) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input logic [7:0] s0, input logic [7:0] s1, input logic [31:0] off,
                                input logic [31:0] w, input logic [31:0] h, input logic [15:0] bpp,
                                input logic [31:0] comp, input logic [2:0] e_err,
                                input logic [15:0] e_w, input logic [15:0] e_h, input logic e_td,
                                input logic [17:0] e_stride, input logic [31:0] e_pix);
        vec_t v;
        v.s0 = s0; v.s1 = s1; v.off = off; v.w = w; v.h = h; v.bpp = bpp; v.comp = comp;
        v.e_err = e_err; v.e_w = e_w; v.e_h = e_h; v.e_td = e_td; v.e_off = off;
        v.e_stride = e_stride; v.e_pix = e_pix;
        return v;
    endfunction

    // Reference model: geometry and error code straight from the header rules.
    function automatic vec_t model(input vec_t v);
        vec_t   r;
        longint hs, mag, stride, pix;
        r  = v;
        hs = longint'(signed'(v.h));
        mag = (hs < 0) ? -hs : hs;
        r.e_h = 16'(mag % 65536);
        r.e_td = (hs < 0);
        r.e_w = 16'(v.w % 65536);
        r.e_off = v.off;
        stride = ((longint'(r.e_w) * 3 + 3) / 4) * 4;
        r.e_stride = 18'(stride);
        pix = (stride * longint'(r.e_h)) % 64'h1_0000_0000;
        r.e_pix = 32'(pix);
        if (v.s0 != 8'h42 || v.s1 != 8'h4D)          r.e_err = 3'd1;
        else if (v.bpp != 16'd24)                    r.e_err = 3'd2;
        else if (v.comp != 0)                        r.e_err = 3'd3;
        else if (v.w == 0 || v.w > 65535 || hs == 0) r.e_err = 3'd4;
        else if (v.off < 54)                         r.e_err = 3'd5;
        else                                         r.e_err = 3'd0;
        return r;
    endfunction

    task automatic load_hdr(input vec_t v);
        for (int i = 0; i < 64; i++) mem[i] = 8'($urandom);
        mem[0] = v.s0;
        mem[1] = v.s1;
        for (int b = 0; b < 4; b++) begin
            mem[10 + b] = v.off[8*b +: 8];
            mem[18 + b] = v.w[8*b +: 8];
            mem[22 + b] = v.h[8*b +: 8];
            mem[30 + b] = v.comp[8*b +: 8];
        end
        mem[28] = v.bpp[7:0];
        mem[29] = v.bpp[15:8];
    endtask

    task automatic run_vec(input vec_t v, input bit extra_starts, input string tag);
        int n;
        int bad;
        int snap;
        bit seen;
        load_hdr(v);
        addr_q.delete();
        @(negedge CLOCK_50);
        start = 1'b1;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
        chk({tag, " busy_at_accept"}, busy, 1);
        chk({tag, " rd_en_at_accept"}, rd_en, 1);
        n = 0;
        seen = 1'b0;
        while (!seen && n < 200) begin
            @(posedge CLOCK_50);
            #1 n++;
            if (extra_starts && n == 10) start = 1'b1;
            if (extra_starts && n == 11) start = 1'b0;
            if (done) seen = 1'b1;
        end
        chk({tag, " done_latency"}, n, 56);
        chk({tag, " busy_at_done"}, busy, 0);
        chk({tag, " err_code"}, err_code, v.e_err);
        chk({tag, " img_width"}, img_width, v.e_w);
        chk({tag, " img_height"}, img_height, v.e_h);
        chk({tag, " top_down"}, top_down, v.e_td);
        chk({tag, " pix_offset"}, pix_offset, v.e_off);
        chk({tag, " row_stride"}, row_stride, v.e_stride);
        chk({tag, " pix_bytes"}, pix_bytes, v.e_pix);
        if (extra_starts) start = 1'b1;
        snap = done_cnt;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
        chk({tag, " done_width"}, done, 0);
        if (extra_starts) begin
            repeat (80) @(posedge CLOCK_50);
            #1 chk({tag, " extra_done_pulses"}, done_cnt - snap, 1);
            chk({tag, " busy_after_ignored_start"}, busy, 0);
        end
        bad = 0;
        foreach (addr_q[i]) if (addr_q[i] != 16'(i)) bad++;
        chk({tag, " rd_count"}, addr_q.size(), 54);
        chk({tag, " rd_addr_seq_errors"}, bad, 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t v;
        int   snap;
        rst_n = 1'b0;
        start = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        chk("rst rd_en", rd_en, 0);
        chk("rst rd_addr", rd_addr, 0);
        chk("rst busy", busy, 0);
        chk("rst done", done, 0);
        chk("rst err_code", err_code, 0);
        chk("rst geometry", {img_width, img_height, top_down, pix_offset, row_stride, pix_bytes}, 0);
        @(negedge CLOCK_50);
        rst_n = 1'b1;

        tbl[0] = mk(8'h42, 8'h4D, 54, 31, 20, 24, 0, 0, 31, 20, 0, 96, 1920);
        tbl[1] = mk(8'h42, 8'h4D, 54, 31, 32'hFFFF_FFEC, 24, 0, 0, 31, 20, 1, 96, 1920);
        tbl[2] = mk(8'h42, 8'h41, 54, 31, 20, 32, 0, 1, 31, 20, 0, 96, 1920);
        tbl[3] = mk(8'h42, 8'h4D, 54, 31, 20, 32, 0, 2, 31, 20, 0, 96, 1920);
        tbl[4] = mk(8'h42, 8'h4D, 54, 0, 20, 24, 0, 4, 0, 20, 0, 0, 0);
        tbl[5] = mk(8'h42, 8'h4D, 40, 31, 20, 24, 0, 5, 31, 20, 0, 96, 1920);
        tbl[6] = mk(8'h42, 8'h4D, 54, 31, 20, 24, 1, 3, 31, 20, 0, 96, 1920);
        tbl[7] = mk(8'h42, 8'h4D, 54, 32'h0010_001F, 20, 24, 0, 4, 31, 20, 0, 96, 1920);
        tbl[8] = mk(8'h42, 8'h4D, 1078, 65535, 65535, 24, 0, 0, 65535, 65535, 0, 18'd196608, 32'hFFFD_0000);

        for (int i = 0; i < 9; i++) run_vec(tbl[i], 1'b0, $sformatf("vec%0d", i));

        // Extra start pulses during READ and in the done cycle.
        run_vec(tbl[0], 1'b1, "starts_ignored");

        // Reset twenty edges into a parse.
        load_hdr(tbl[1]);
        @(negedge CLOCK_50);
        start = 1'b1;
        @(posedge CLOCK_50);
        #1 start = 1'b0;
        repeat (20) @(posedge CLOCK_50);
        #1 rst_n = 1'b0;
        snap = done_cnt;
        #1;
        chk("abort rd_en", rd_en, 0);
        chk("abort busy", busy, 0);
        chk("abort geometry", {img_width, img_height, top_down, pix_offset, row_stride, pix_bytes}, 0);
        repeat (4) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        rst_n = 1'b1;
        repeat (60) @(posedge CLOCK_50);
        #1 chk("abort no_done", done_cnt - snap, 0);
        run_vec(tbl[0], 1'b0, "after_abort");

        for (int k = 0; k < 40; k++) begin
            v.s0 = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h42;
            v.s1 = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'h4D;
            v.off = ($urandom_range(0, 5) == 0) ? 32'($urandom_range(0, 60)) : 32'(54 + $urandom_range(0, 2000));
            case ($urandom_range(0, 9))
                0:       v.w = 0;
                1:       v.w = $urandom;
                default: v.w = 32'($urandom_range(1, 65535));
            endcase
            case ($urandom_range(0, 9))
                0:          v.h = 0;
                1, 2, 3, 4: v.h = -32'($urandom_range(1, 65535));
                5:          v.h = $urandom;
                default:    v.h = 32'($urandom_range(1, 65535));
            endcase
            v.bpp  = ($urandom_range(0, 7) == 0) ? 16'($urandom) : 16'd24;
            v.comp = ($urandom_range(0, 7) == 0) ? 32'($urandom_range(0, 3)) : 32'd0;
            v = model(v);
            run_vec(v, 1'b0, $sformatf("rand%0d", k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
